// File: rtl/perceptron_pkg.sv
// Shared widths and FSM encoding for the perceptron layer sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package perceptron_pkg;

  localparam int DATA_W = 18;  // lane width of x and w
  localparam int ACC_W  = 48;  // weighted-sum width

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/valid_tag_pipe.sv
// Reset-clearable shift-register delay line carrying a {valid, tag} word.
// Latency: DEPTH clk cycles from i_dat to o_dat.
// Backpressure: none; a word is pushed every cycle.
// Ports: clk, rst_n (async active-low), i_dat [WIDTH] in, o_dat [WIDTH] out.
module valid_tag_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_dat;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_dat = r_stage[DEPTH-1];

endmodule

// File: rtl/perceptron_layer_sequencer.sv
// Sequences one single-layer perceptron evaluation over the shared weighted-sum datapath.
// Latency: start -> done is M+2+LATENCY cycles; row k retires in cycle k+2+LATENCY.
// Backpressure: none; one row issued per cycle, start ignored while busy.
// Ports: clk, rst_n; start/x_in/threshold in, busy/done out; weight RAM w_rd_en/w_addr out,
//        w_rd_data in; datapath ws_x/ws_w out, ws_sum in; sum_valid/sum_idx/y out.
module perceptron_layer_sequencer
  import perceptron_pkg::*;
#(
  parameter int N       = 16,
  parameter int M       = 8,
  parameter int LATENCY = N + 3,
  parameter int AW      = (M > 1) ? $clog2(M) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_W*N-1:0] x_in,
  input  logic [ACC_W-1:0]    threshold,
  output logic                busy,
  output logic                done,
  output logic                w_rd_en,
  output logic [AW-1:0]       w_addr,
  input  logic [DATA_W*N-1:0] w_rd_data,
  output logic [DATA_W*N-1:0] ws_x,
  output logic [DATA_W*N-1:0] ws_w,
  input  logic [ACC_W-1:0]    ws_sum,
  output logic                sum_valid,
  output logic [AW-1:0]       sum_idx,
  output logic [M-1:0]        y
);

  localparam int CW = $clog2(M + 1);
  localparam int TW = 1 + AW;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W*N-1:0] r_x;
  logic [ACC_W-1:0]    r_thr;
  logic [AW-1:0]       r_addr;
  logic                r_rd_vld;   // RAM data for an issued row is on w_rd_data
  logic [CW-1:0]       r_ret_cnt;
  logic [M-1:0]        r_y;
  logic                w_accept;
  logic                w_issue;
  logic                w_last_issue;
  logic                w_retire;
  logic                w_last_retire;
  logic [TW-1:0]       w_tag_in;
  logic [TW-1:0]       w_tag_out;

  assign w_accept      = (r_state == S_IDLE) && start;
  assign w_last_issue  = (r_state == S_ISSUE) && (r_addr == AW'(M - 1));
  assign w_retire      = w_tag_out[AW];
  assign w_last_retire = w_retire && (r_ret_cnt == CW'(M - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_issue = 1'b1;
        if (w_last_issue) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // done lands the cycle after the final retire, never with it
        if (w_last_retire) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_thr     <= '0;
      r_addr    <= '0;
      r_rd_vld  <= 1'b0;
      r_ret_cnt <= '0;
      r_y       <= '0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_accept) begin
        r_x       <= x_in;
        r_thr     <= threshold;
        r_addr    <= '0;
        r_ret_cnt <= '0;
        r_y       <= '0;
      end else begin
        // address parks at M-1 once the last row is issued
        if (w_issue && !w_last_issue) r_addr <= r_addr + AW'(1);
        if (w_retire) begin
          r_y[w_tag_out[AW-1:0]] <= (ws_sum >= r_thr);
          r_ret_cnt              <= r_ret_cnt + CW'(1);
        end
      end
    end
  end

  // Tag enters alongside the read request; the extra stage covers the RAM read cycle.
  assign w_tag_in = {w_issue, r_addr};

  valid_tag_pipe #(
    .WIDTH (TW),
    .DEPTH (1 + LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_dat (w_tag_in),
    .o_dat (w_tag_out)
  );

  assign w_rd_en   = w_issue;
  assign w_addr    = r_addr;
  // Zero the datapath inputs outside live rows so idle lanes sum to zero.
  assign ws_x      = r_rd_vld ? r_x : '0;
  assign ws_w      = r_rd_vld ? w_rd_data : '0;
  assign sum_valid = w_tag_out[AW];
  assign sum_idx   = w_tag_out[AW-1:0];
  assign y         = r_y;

endmodule

// File: tb/tb_perceptron_layer_sequencer.sv
// Bench for perceptron_layer_sequencer with a behavioural weight RAM and weighted-sum datapath.
// Latency: datapath model delays the lane dot product by LAT cycles.
// Backpressure: n/a.
module tb_perceptron_layer_sequencer;

  localparam int N   = 16;
  localparam int M   = 4;
  localparam int LAT = N + 3;
  localparam int AW  = 2;
  localparam int DW  = 18;
  localparam int XW  = DW * N;
  localparam int DONE_CYC = M + 2 + LAT;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [XW-1:0] x_in;
  logic [47:0]   threshold;
  logic          busy;
  logic          done;
  logic          w_rd_en;
  logic [AW-1:0] w_addr;
  logic [XW-1:0] w_rd_data;
  logic [XW-1:0] ws_x;
  logic [XW-1:0] ws_w;
  logic [47:0]   ws_sum;
  logic          sum_valid;
  logic [AW-1:0] sum_idx;
  logic [M-1:0]  y;

  perceptron_layer_sequencer #(
    .N(N), .M(M), .LATENCY(LAT), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .threshold(threshold),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd_data(w_rd_data),
    .ws_x(ws_x), .ws_w(ws_w), .ws_sum(ws_sum), .sum_valid(sum_valid), .sum_idx(sum_idx), .y(y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous weight RAM, 1-cycle read.
  logic [XW-1:0] ram [M];
  logic [XW-1:0] ram_q;
  always @(posedge clk) if (w_rd_en) ram_q <= ram[w_addr];
  assign w_rd_data = ram_q;

  // Behavioural weighted-sum datapath.
  function automatic logic [47:0] dot(input logic [XW-1:0] a, input logic [XW-1:0] b);
    logic signed [47:0]   acc;
    logic signed [DW-1:0] la;
    logic signed [DW-1:0] lb;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      la = a[i*DW +: DW];
      lb = b[i*DW +: DW];
      acc += 48'(la) * 48'(lb);
    end
    return acc;
  endfunction

  logic [47:0] sp [LAT];
  always @(posedge clk) begin
    sp[0] <= dot(ws_x, ws_w);
    for (int i = 1; i < LAT; i++) sp[i] <= sp[i-1];
  end
  assign ws_sum = sp[LAT-1];

  function automatic logic [XW-1:0] splat(input int v);
    logic [XW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  typedef struct {
    logic [AW-1:0] idx;
    logic [47:0]   sum;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; x_in = splat(7); threshold = '0;
    repeat (3) @(negedge clk);
    n_checks++; if ({busy, done, w_rd_en, sum_valid} !== 4'b0000) $display("FAIL reset_ctrl: got %b want 0000", {busy, done, w_rd_en, sum_valid}); else n_pass++;
    n_checks++; if ({w_addr, sum_idx} !== '0) $display("FAIL reset_addr: got %h want 0", {w_addr, sum_idx}); else n_pass++;
    n_checks++; if (y !== '0) $display("FAIL reset_y: got %b want 0000", y); else n_pass++;
    n_checks++; if ((ws_x !== '0) || (ws_w !== '0)) $display("FAIL reset_ws: got nonzero ws_x/ws_w want 0"); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge of the cycle after done.
  task automatic run_eval(input string name, input int xv, input logic [47:0] thr,
                          input int rp_a, input int rp_b, input int abort_cyc);
    logic [M-1:0]  y_exp;
    logic [XW-1:0] xvec;
    logic [47:0]   s;
    exp_t          e;
    int cyc, done_cnt, done_cyc, bad_cyc, ab_done;
    bit exp_rd, exp_ws, exp_busy;
    xvec = splat(xv);
    y_exp = '0;
    for (int k = 0; k < M; k++) begin
      s = 48'(N * xv * (k + 2));
      e.idx = AW'(k);
      e.sum = s;
      sb.push_back(e);
      y_exp[k] = (s >= thr);
    end
    x_in = xvec; threshold = thr; start = 1'b1;
    @(negedge clk);
    start = 1'b0; x_in = splat(999); threshold = '1;
    cyc = 1; done_cnt = 0; done_cyc = -1; bad_cyc = -1;
    n_checks++; if (y !== '0) $display("FAIL %s y_clear: got %b want 0000", name, y); else n_pass++;
    while (cyc <= 60) begin
      if (cyc == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        n_checks++; if ({busy, done, w_rd_en, sum_valid} !== 4'b0000) $display("FAIL %s abort_ctrl: got %b want 0000", name, {busy, done, w_rd_en, sum_valid}); else n_pass++;
        n_checks++; if ({w_addr, sum_idx, y} !== '0) $display("FAIL %s abort_regs: got %h want 0", name, {w_addr, sum_idx, y}); else n_pass++;
        n_checks++; if ((ws_x !== '0) || (ws_w !== '0)) $display("FAIL %s abort_ws: got nonzero want 0", name); else n_pass++;
        ab_done = 0;
        repeat (3) begin @(negedge clk); if (done !== 1'b0 || sum_valid !== 1'b0) ab_done++; end
        rst_n = 1'b1;
        repeat (LAT + 8) begin @(negedge clk); if (done !== 1'b0 || sum_valid !== 1'b0) ab_done++; end
        n_checks++; if (ab_done !== 0) $display("FAIL %s abort_no_done: got %0d cycles with done/sum_valid want 0", name, ab_done); else n_pass++;
        sb.delete();
        return;
      end
      start = (cyc == rp_a || cyc == rp_b);
      exp_rd   = (cyc >= 1 && cyc <= M);
      exp_ws   = (cyc >= 2 && cyc <= M + 1);
      exp_busy = (cyc <= DONE_CYC);
      if (bad_cyc < 0) begin
        if (w_rd_en !== exp_rd || (exp_rd && w_addr !== AW'(cyc - 1)) || busy !== exp_busy ||
            ws_x !== (exp_ws ? xvec : '0) || ws_w !== (exp_ws ? splat(cyc) : '0))
          bad_cyc = cyc;
      end
      if (sum_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++; $display("FAIL %s sb_empty: got sum_valid at cycle %0d want none", name, cyc);
        end else begin
          e = sb.pop_front();
          n_checks++; if (sum_idx !== e.idx) $display("FAIL %s sum_idx: got %0d want %0d", name, sum_idx, e.idx); else n_pass++;
          n_checks++; if (ws_sum !== e.sum) $display("FAIL %s sum_val: got %0d want %0d", name, ws_sum, e.sum); else n_pass++;
          n_checks++; if (cyc !== int'(e.idx) + 2 + LAT) $display("FAIL %s sum_cycle: got %0d want %0d", name, cyc, int'(e.idx) + 2 + LAT); else n_pass++;
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) break;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_checks++; if (done_cyc !== DONE_CYC) $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, DONE_CYC); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL %s done_count: got %0d want 1", name, done_cnt); else n_pass++;
    n_checks++; if (bad_cyc !== -1) $display("FAIL %s ctrl_pattern: got deviation at cycle %0d want none", name, bad_cyc); else n_pass++;
    n_checks++; if (sb.size() !== 0) $display("FAIL %s sb_left: got %0d pending want 0", name, sb.size()); else n_pass++;
    n_checks++; if (y !== y_exp) $display("FAIL %s y: got %b want %b", name, y, y_exp); else n_pass++;
    sb.delete();
  endtask

  task automatic test_basic();
    run_eval("basic", 10, 48'd500, -1, -1, -1);
  endtask

  task automatic test_threshold_edge();
    run_eval("thr_eq", 10, 48'd480, -1, -1, -1);
    run_eval("thr_zero", 10, 48'd0, -1, -1, -1);
  endtask

  task automatic test_busy_start();
    run_eval("busy_start", 10, 48'd500, 3, 15, -1);
  endtask

  task automatic test_reset_abort();
    run_eval("abort", 10, 48'd500, -1, -1, 10);
    run_eval("after_abort", 10, 48'd500, -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    run_eval("b2b_first", 10, 48'd640, -1, -1, -1);
    run_eval("b2b_second", 3, 48'd200, -1, -1, -1);
  endtask

  task automatic test_idle_lanes();
    int sv_seen;
    sv_seen = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (sum_valid !== 1'b0) sv_seen++;
    end
    n_checks++; if (sv_seen !== 0) $display("FAIL idle_sum_valid: got %0d cycles want 0", sv_seen); else n_pass++;
    n_checks++; if ((ws_x !== '0) || (ws_w !== '0)) $display("FAIL idle_ws: got nonzero want 0"); else n_pass++;
    n_checks++; if (ws_sum !== 48'd0) $display("FAIL idle_sum: got %0d want 0", ws_sum); else n_pass++;
    n_checks++; if ({busy, done} !== 2'b00) $display("FAIL idle_ctrl: got %b want 00", {busy, done}); else n_pass++;
  endtask

  initial begin
    for (int k = 0; k < M; k++) ram[k] = splat(k + 2);
    test_reset();
    test_basic();
    test_threshold_edge();
    test_busy_start();
    test_reset_abort();
    test_back_to_back();
    test_idle_lanes();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
